// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: N-channel hobby-servo PWM generator with per-channel slew limiting,
// output enables, a debounced active-low latch key and per-channel settled flags.
module servo_pwm_bank #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned DUTY_W       = 8,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned FRAME_US     = 20000,
    parameter int unsigned MIN_US       = 1000,
    parameter int unsigned MAX_US       = 2000,
    parameter int unsigned SLEW_STEP    = 4,
    parameter int unsigned DEBOUNCE_CYC = 250_000,
    localparam int unsigned SEL_W       = (CHANNELS > 32'd1) ? $clog2(CHANNELS) : 32'd1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DUTY_W-1:0]   duty_i,
    input  logic [SEL_W-1:0]    channel_sel_i,
    input  logic                latch_ni,
    input  logic [CHANNELS-1:0] en_i,
    output logic [CHANNELS-1:0] pwm_out_o,
    output logic [CHANNELS-1:0] settled_o
);
    localparam int unsigned CYC_PER_US = CLK_HZ / 32'd1_000_000;
    localparam int unsigned FRAME_CYC  = CYC_PER_US * FRAME_US;
    localparam int unsigned MIN_CYC    = CYC_PER_US * MIN_US;
    localparam int unsigned SPAN_CYC   = CYC_PER_US * (MAX_US - MIN_US);
    localparam int unsigned STEP_CYC   = SPAN_CYC / ((32'd1 << DUTY_W) - 32'd1);
    localparam int unsigned TOP_CYC    = (FRAME_CYC > (MIN_CYC + SPAN_CYC + 32'd1)) ?
                                         FRAME_CYC : (MIN_CYC + SPAN_CYC + 32'd1);
    localparam int unsigned CNT_W      = $clog2(TOP_CYC);
    localparam int unsigned DB_W       = (DEBOUNCE_CYC > 32'd1) ? $clog2(DEBOUNCE_CYC) : 32'd1;

    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_CYC - 32'd1);
    localparam logic [CNT_W-1:0]  MIN_V      = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0]  STEP_V     = CNT_W'(STEP_CYC);
    localparam logic [CNT_W-1:0]  ONE_CNT    = CNT_W'(1'b1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYC - 32'd1);
    localparam logic [DB_W-1:0]   ONE_DB     = DB_W'(1'b1);
    localparam logic [DUTY_W:0]   SLEW_V     = (DUTY_W + 1)'(SLEW_STEP);
    localparam logic [DUTY_W-1:0] CENTRE     = DUTY_W'(32'd1 << (DUTY_W - 32'd1));

    typedef logic [DUTY_W-1:0] code_t;

    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                frame_end_s;
    logic [1:0]          sync_q;
    logic                deb_q, deb_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic                load_s;
    code_t               target_q [CHANNELS];
    code_t               target_d [CHANNELS];
    code_t               pos_q    [CHANNELS];
    code_t               pos_d    [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0] settled_q, settled_d;

    function automatic logic [CNT_W-1:0] high_cyc_f(input code_t code);
        high_cyc_f = MIN_V + (CNT_W'(code) * STEP_V);
    endfunction

    function automatic code_t slew_f(input code_t cur, input code_t tgt);
        logic [DUTY_W:0] diff;
        diff = '0;
        if (SLEW_STEP == 32'd0) begin
            slew_f = tgt;
        end else if (tgt > cur) begin
            diff   = {1'b0, tgt} - {1'b0, cur};
            slew_f = (diff > SLEW_V) ? (cur + SLEW_V[DUTY_W-1:0]) : tgt;
        end else begin
            diff   = {1'b0, cur} - {1'b0, tgt};
            slew_f = (diff > SLEW_V) ? (cur - SLEW_V[DUTY_W-1:0]) : tgt;
        end
    endfunction

    // Free-running frame counter; its last count is the slew update point.
    always_comb begin
        frame_end_s = (frame_cnt_q == FRAME_LAST);
        if (frame_end_s) begin
            frame_cnt_d = '0;
        end else begin
            frame_cnt_d = frame_cnt_q + ONE_CNT;
        end
    end

    // Debouncer: adopt the synchronised level after DEBOUNCE_CYC consecutive differing cycles.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (DEBOUNCE_CYC == 32'd0) begin
            deb_d = sync_q[1];
        end else if (sync_q[1] != deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                deb_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + ONE_DB;
            end
        end else begin
            db_cnt_d = '0;
        end
        load_s = deb_q & ~deb_d;
    end

    // Per-channel slew (using the pre-load target), target load, pulse compare, settled flag.
    always_comb begin
        target_d  = target_q;
        pos_d     = pos_q;
        pwm_d     = '0;
        settled_d = '0;
        for (int unsigned i = 32'd0; i < CHANNELS; i++) begin
            if (frame_end_s) begin
                pos_d[i] = slew_f(pos_q[i], target_q[i]);
            end else begin
                pos_d[i] = pos_q[i];
            end
            if (load_s && (32'(channel_sel_i) == i)) begin
                target_d[i] = duty_i;
            end else begin
                target_d[i] = target_q[i];
            end
            pwm_d[i]     = en_i[i] & (frame_cnt_q < high_cyc_f(pos_q[i]));
            settled_d[i] = (pos_q[i] == target_q[i]);
        end
    end

    // Frame counter, key synchroniser and debounce state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            sync_q      <= 2'b11;
            deb_q       <= 1'b1;
            db_cnt_q    <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            sync_q      <= {sync_q[0], latch_ni};
            deb_q       <= deb_d;
            db_cnt_q    <= db_cnt_d;
        end
    end

    // Channel positions, targets and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_q  <= '{default: CENTRE};
            pos_q     <= '{default: CENTRE};
            pwm_q     <= '0;
            settled_q <= '1;
        end else begin
            target_q  <= target_d;
            pos_q     <= pos_d;
            pwm_q     <= pwm_d;
            settled_q <= settled_d;
        end
    end

    assign pwm_out_o = pwm_q;
    assign settled_o = settled_q;
endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: two scaled-down instances (slew 2 / 4 channels, slew 0 / 3 channels)
// checked every cycle against a rule-level model, plus table vectors and directed corner cases.
module tb_servo_pwm_bank;
    localparam int CH     = 4;
    localparam int CH0    = 3;
    localparam int FRAME  = 400;
    localparam int DEB    = 20;
    localparam int MINC   = 100;
    localparam int STEPC  = 6;
    localparam int SLEW   = 2;
    localparam int CENTRE = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] duty    = 4'd0;
    logic [1:0] sel     = 2'd0;
    logic       latch_n = 1'b1;
    logic [3:0] en      = 4'hF;
    logic [3:0] pwm, set;
    logic [2:0] pwm0, set0;

    always #5 clk = ~clk;

    servo_pwm_bank #(.CHANNELS(4), .DUTY_W(4), .CLK_HZ(1_000_000), .FRAME_US(400),
        .MIN_US(100), .MAX_US(200), .SLEW_STEP(2), .DEBOUNCE_CYC(20)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .duty_i(duty), .channel_sel_i(sel),
        .latch_ni(latch_n), .en_i(en), .pwm_out_o(pwm), .settled_o(set));

    servo_pwm_bank #(.CHANNELS(3), .DUTY_W(4), .CLK_HZ(1_000_000), .FRAME_US(400),
        .MIN_US(100), .MAX_US(200), .SLEW_STEP(0), .DEBOUNCE_CYC(20)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .duty_i(duty), .channel_sel_i(sel),
        .latch_ni(latch_n), .en_i(en[2:0]), .pwm_out_o(pwm0), .settled_o(set0));

    // Reference model state: frame position, codes, key history.
    int   m_frame;
    int   m_tgt [CH];
    int   m_pos [CH];
    int   z_tgt [CH0];
    int   z_pos [CH0];
    bit   m_deb;
    bit   dly [$];
    bit   win [$];
    logic [3:0] e_pwm, e_set;
    logic [2:0] e_pwm0, e_set0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] duty;
        logic [2:0] en;
        int         w_a;
        int         w_b;
        int         w_c;
    } vec_t;
    vec_t vecs [6];

    function automatic int hi(int code);
        return MINC + code * STEPC;
    endfunction

    function automatic int slew_to(int cur, int tgt, int step);
        int d = tgt - cur;
        if (step == 0) return tgt;
        if (d > step) return cur + step;
        if (d < -step) return cur - step;
        return tgt;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame = 0;
        foreach (m_tgt[i]) begin m_tgt[i] = CENTRE; m_pos[i] = CENTRE; end
        foreach (z_tgt[i]) begin z_tgt[i] = CENTRE; z_pos[i] = CENTRE; end
        m_deb = 1'b1;
        dly = '{1'b1, 1'b1};
        win.delete();
        e_pwm = 4'h0; e_set = 4'hF; e_pwm0 = 3'h0; e_set0 = 3'h7;
    endtask

    // One clock of the specification rules, applied to the state before the edge.
    task automatic model_step();
        bit s2;
        bit flip;
        for (int i = 0; i < CH; i++) begin
            e_pwm[i] = en[i] && (m_frame < hi(m_pos[i]));
            e_set[i] = (m_pos[i] == m_tgt[i]);
        end
        for (int i = 0; i < CH0; i++) begin
            e_pwm0[i] = en[i] && (m_frame < hi(z_pos[i]));
            e_set0[i] = (z_pos[i] == z_tgt[i]);
        end
        s2 = dly.pop_front();
        dly.push_back(latch_n);
        win.push_back(s2);
        if (win.size() > DEB) void'(win.pop_front());
        flip = (win.size() == DEB);
        foreach (win[k]) if (win[k] == m_deb) flip = 1'b0;
        if (m_frame == FRAME - 1) begin
            for (int i = 0; i < CH; i++) m_pos[i] = slew_to(m_pos[i], m_tgt[i], SLEW);
            for (int i = 0; i < CH0; i++) z_pos[i] = z_tgt[i];
        end
        if (flip) begin
            if (m_deb) begin
                if (int'(sel) < CH) m_tgt[sel] = duty;
                if (int'(sel) < CH0) z_tgt[sel] = duty;
            end
            m_deb = s2;
        end
        m_frame = (m_frame + 1) % FRAME;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        cyc++;
        @(negedge clk);
        check("outputs", {18'd0, pwm, set, 1'b0, pwm0, 1'b0, set0},
                         {18'd0, e_pwm, e_set, 1'b0, e_pwm0, 1'b0, e_set0});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        latch_n = 1'b1;
        model_reset();
        #1;
        check("rst_pwm", {pwm0, pwm}, 7'h00);
        check("rst_settled", {set0, set}, 7'h7F);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic press(int n);
        latch_n = 1'b0;
        repeat (n) tick();
        latch_n = 1'b1;
        repeat (DEB + 10) tick();
    endtask

    // Pulse-high counts over one full frame, starting where the model frame begins.
    task automatic measure(output int w [CH], output int w0 [CH0]);
        int guard = 0;
        foreach (w[i]) w[i] = 0;
        foreach (w0[i]) w0[i] = 0;
        while (m_frame != 1 && guard < FRAME + 2) begin tick(); guard++; end
        check("frame_align", m_frame, 1);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick();
            foreach (w[i]) w[i] += int'(pwm[i]);
            foreach (w0[i]) w0[i] += int'(pwm0[i]);
        end
    endtask

    task automatic rise_time(output int t);
        logic prev;
        int   guard = 0;
        t = -1;
        prev = pwm[0];
        while (guard < 2 * FRAME) begin
            tick(); guard++;
            if (!prev && pwm[0]) begin t = cyc; break; end
            prev = pwm[0];
        end
        check("rise_seen", t >= 0, 1'b1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w [CH];
        int w0 [CH0];
        int t0, t1, lat, falls, highs, hold;
        logic prev;
        int exp_w [5] = '{136, 124, 112, 100, 100};
        logic exp_s [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        vecs[0] = '{2'd0, 4'd15, 3'b111, 190, 148, 148};
        vecs[1] = '{2'd1, 4'd0,  3'b111, 190, 100, 148};
        vecs[2] = '{2'd2, 4'd5,  3'b111, 190, 100, 130};
        vecs[3] = '{2'd3, 4'd1,  3'b111, 190, 100, 130};
        vecs[4] = '{2'd0, 4'd8,  3'b111, 148, 100, 130};
        vecs[5] = '{2'd1, 4'd15, 3'b101, 148, 0,   130};

        // Centre pulses and frame period after reset.
        @(negedge clk);
        do_reset();
        measure(w, w0);
        foreach (w[i]) check("centre_width", w[i], 148);
        check("centre_settled", set, 4'hF);
        rise_time(t0);
        rise_time(t1);
        check("period", t1 - t0, FRAME);

        // Slew 0 instance: debounced load latency and full-scale jump.
        do_reset();
        duty = 4'd15; sel = 2'd0; latch_n = 1'b0; lat = 0;
        do begin tick(); lat++; end while (set0[0] && lat < 100);
        check("load_latency", lat, DEB + 3);
        repeat (60 - lat) tick();
        latch_n = 1'b1;
        repeat (30) tick();
        measure(w, w0);
        check("jump_ch0", w0[0], 190);
        check("jump_ch1", w0[1], 148);
        check("jump_ch2", w0[2], 148);

        // Slew-limited descent of channel 2 from centre to 0.
        do_reset();
        duty = 4'd0; sel = 2'd2;
        press(40);
        for (int f = 0; f < 5; f++) begin
            measure(w, w0);
            check("slew_width", w[2], exp_w[f]);
            check("slew_settled", set[2], exp_s[f]);
            check("slew_other", w[1], 148);
        end

        // Short glitch ignored; a long hold loads exactly once.
        do_reset();
        duty = 4'd3; sel = 2'd1;
        latch_n = 1'b0; repeat (10) tick(); latch_n = 1'b1;
        repeat (40) tick();
        check("glitch_noload", set0, 3'b111);
        falls = 0; prev = set0[1]; latch_n = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k == 100) duty = 4'd12;
            tick();
            if (prev && !set0[1]) falls++;
            prev = set0[1];
        end
        latch_n = 1'b1;
        repeat (40) tick();
        measure(w, w0);
        check("hold_one_load", falls, 1);
        check("hold_width", w0[1], 118);

        // Enable dropped mid-pulse, restored after the pulse window.
        do_reset();
        while (m_frame != 50) tick();
        check("en_before", pwm[1], 1'b1);
        en[1] = 1'b0;
        tick();
        check("en_drop", pwm[1], 1'b0);
        highs = 0;
        while (m_frame != 300) begin tick(); highs += int'(pwm[1]); end
        check("en_stays_low", highs, 0);
        en[1] = 1'b1;
        measure(w, w0);
        check("en_resume", w[1], 148);

        // Reset asserted mid-pulse with a loaded target.
        do_reset();
        duty = 4'd15; sel = 2'd0;
        press(40);
        measure(w, w0);
        check("pre_rst_width", w0[0], 190);
        while (m_frame != 60) tick();
        check("pre_rst_high", pwm0[0], 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_pwm", {pwm0, pwm}, 7'h00);
        check("rst_mid_settled", {set0, set}, 7'h7F);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("restart_edge", {pwm0, pwm}, 7'h7F);
        measure(w, w0);
        check("restart_w", w[0], 148);
        check("restart_w0", w0[0], 148);

        // Table-driven loads on the slew-0 instance, including an out-of-range select.
        do_reset();
        foreach (vecs[v]) begin
            duty = vecs[v].duty; sel = vecs[v].sel; en = {1'b1, vecs[v].en};
            press(30);
            measure(w, w0);
            check("vec_ch0", w0[0], vecs[v].w_a);
            check("vec_ch1", w0[1], vecs[v].w_b);
            check("vec_ch2", w0[2], vecs[v].w_c);
        end

        // Randomised key, code, select and enable traffic against the model.
        do_reset();
        hold = 0;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                latch_n = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 45));
            end
            hold--;
            duty = 4'($urandom);
            sel = 2'($urandom);
            if (k % 150 == 0) en = 4'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
